mem_sb_checker: RTL and testbench

- Synthesizable, parametrised scoreboard checker for single-port RAMs. It sits passively on the RAM pins and drives no RAM signals.
- Shadows writes in a direct-mapped tag/data table and compares each read's returned data against the expected value after a configurable read latency.
- Detects read-before-write, data mismatch and illegal commands, reporting each with sticky flags, saturating counters and an error capture record.

---
 rtl/mem_sb_checker.sv | 193 +++++++++++++++++++
 tb/tb_mem_sb_checker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sb_checker.sv
// rtl/mem_sb_checker.sv - passive scoreboard checker for a single-port RAM
//
// Watches the RAM command pins without driving them. Writes are shadowed in a
// direct-mapped tag/data table. Each read that hits the table has its expected
// data compared with rdata READ_LATENCY cycles later. Reads that miss and
// illegal commands are also reported.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   read_write, cs, oe   RAM command (1=write / chip select / output enable)
//   address, wdata       RAM address and write data
//   rdata                RAM read data, valid READ_LATENCY cycles after a read
//   clr                  synchronous clear of stats, flags, capture and table
//   err_mismatch/rbw/illegal  sticky error flags
//   err_pulse            one-cycle pulse on any new error
//   err_addr/exp/act     capture record of the most recent error
//   pass_cnt, mismatch_cnt, rbw_cnt  saturating statistics counters
//
// Optional: define MEM_SB_XCHECK_EN to flag X/Z on address, wdata and compared
// rdata (simulation only).
module mem_sb_checker #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 30,
  parameter int IDX_WIDTH     = 10,
  parameter int READ_LATENCY  = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     read_write,
  input  logic                     cs,
  input  logic                     oe,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [DATA_WIDTH-1:0]    rdata,
  input  logic                     clr,
  output logic                     err_mismatch,
  output logic                     err_rbw,
  output logic                     err_illegal,
  output logic                     err_pulse,
  output logic [ADDRESS_WIDTH-1:0] err_addr,
  output logic [DATA_WIDTH-1:0]    err_exp,
  output logic [DATA_WIDTH-1:0]    err_act,
  output logic [CNT_WIDTH-1:0]     pass_cnt,
  output logic [CNT_WIDTH-1:0]     mismatch_cnt,
  output logic [CNT_WIDTH-1:0]     rbw_cnt
);

  localparam int ENTRIES   = 1 << IDX_WIDTH;
  // An empty tag (IDX_WIDTH == ADDRESS_WIDTH) is kept as one constant-zero bit
  // so every valid entry compares as a hit.
  localparam int TAG_WIDTH = (ADDRESS_WIDTH > IDX_WIDTH) ? ADDRESS_WIDTH - IDX_WIDTH : 1;
  localparam int LAST      = READ_LATENCY - 1;

  logic [ENTRIES-1:0]    valid;
  logic [TAG_WIDTH-1:0]  tag_mem  [ENTRIES];
  logic [DATA_WIDTH-1:0] data_mem [ENTRIES];

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [ADDRESS_WIDTH-1:0] pipe_addr [READ_LATENCY];
  logic [DATA_WIDTH-1:0]    pipe_exp  [READ_LATENCY];

  logic [IDX_WIDTH-1:0] idx;
  logic [TAG_WIDTH-1:0] tag;
  logic wr, rd, ill, hit;
  logic wr_upd, rd_hit, rd_miss;
  logic cmp_vld, cmp_ok, cmp_bad;
  logic x_addr, x_cmd, x_rdata;
  logic ill_evt;

  assign idx = address[IDX_WIDTH-1:0];
  assign tag = TAG_WIDTH'(address >> IDX_WIDTH);

  // A command in a clr cycle is dropped entirely.
  assign wr  =  read_write & cs & ~oe & ~clr;
  assign rd  = ~read_write & cs &  oe & ~clr;
  assign ill =  read_write & cs &  oe & ~clr;
  assign hit = valid[idx] & (tag_mem[idx] == tag);

  assign cmp_vld = pipe_vld[LAST];

`ifdef MEM_SB_XCHECK_EN
  always_comb begin
    x_addr  = (wr | rd | ill) & $isunknown(address);
    x_cmd   = x_addr | (wr & $isunknown(wdata));
    x_rdata = cmp_vld & ~clr & $isunknown(rdata);
  end
`else
  assign x_addr  = 1'b0;
  assign x_cmd   = 1'b0;
  assign x_rdata = 1'b0;
`endif

  assign wr_upd  = wr & ~x_addr;
  assign rd_hit  = rd & ~x_addr & hit;
  assign rd_miss = rd & ~x_addr & ~hit;
  assign cmp_ok  = cmp_vld & ~clr & ~x_rdata & (rdata == pipe_exp[LAST]);
  assign cmp_bad = cmp_vld & ~clr & ~x_rdata & (rdata != pipe_exp[LAST]);
  assign ill_evt = ill | x_cmd | x_rdata;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Valid bits need reset/clear; tag and data storage does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (clr) begin
      valid <= '0;
    end else if (wr_upd) begin
      valid[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_upd) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= wdata;
    end
  end

  // Expected data is frozen at read issue, so later writes cannot affect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_addr[i] <= '0;
        pipe_exp[i]  <= '0;
      end
    end else if (clr) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0]  <= rd_hit;
      pipe_addr[0] <= address;
      pipe_exp[0]  <= data_mem[idx];
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_exp[i]  <= pipe_exp[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_mismatch <= 1'b0;
      err_rbw      <= 1'b0;
      err_illegal  <= 1'b0;
      err_pulse    <= 1'b0;
      err_addr     <= '0;
      err_exp      <= '0;
      err_act      <= '0;
      pass_cnt     <= '0;
      mismatch_cnt <= '0;
      rbw_cnt      <= '0;
    end else if (clr) begin
      err_mismatch <= 1'b0;
      err_rbw      <= 1'b0;
      err_illegal  <= 1'b0;
      err_pulse    <= 1'b0;
      err_addr     <= '0;
      err_exp      <= '0;
      err_act      <= '0;
      pass_cnt     <= '0;
      mismatch_cnt <= '0;
      rbw_cnt      <= '0;
    end else begin
      err_pulse <= cmp_bad | rd_miss | ill_evt;
      if (cmp_ok) pass_cnt <= sat_inc(pass_cnt);
      if (cmp_bad) begin
        mismatch_cnt <= sat_inc(mismatch_cnt);
        err_mismatch <= 1'b1;
      end
      if (rd_miss) begin
        rbw_cnt <= sat_inc(rbw_cnt);
        err_rbw <= 1'b1;
      end
      if (ill_evt) err_illegal <= 1'b1;
      // A mismatch completing alongside another error owns the capture record.
      if (cmp_bad) begin
        err_addr <= pipe_addr[LAST];
        err_exp  <= pipe_exp[LAST];
        err_act  <= rdata;
      end else if (rd_miss | ill | x_cmd) begin
        err_addr <= address;
      end else if (x_rdata) begin
        err_addr <= pipe_addr[LAST];
      end
    end
  end

endmodule

// File: tb/tb_mem_sb_checker.sv
// tb/tb_mem_sb_checker.sv - randomized scoreboard bench for mem_sb_checker
module tb_mem_sb_checker;
  localparam int DW = 8;
  localparam int AW = 30;
  localparam int IW = 10;
  localparam int RL = 3;
  localparam int CW = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic read_write = 1'b0, cs = 1'b0, oe = 1'b0, clr = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] wdata = '0, rdata = '0;
  logic err_mismatch, err_rbw, err_illegal, err_pulse;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_exp, err_act;
  logic [CW-1:0] pass_cnt, mismatch_cnt, rbw_cnt;

  mem_sb_checker #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .IDX_WIDTH(IW),
    .READ_LATENCY(RL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .read_write(read_write), .cs(cs), .oe(oe),
    .address(address), .wdata(wdata), .rdata(rdata), .clr(clr),
    .err_mismatch(err_mismatch), .err_rbw(err_rbw), .err_illegal(err_illegal),
    .err_pulse(err_pulse), .err_addr(err_addr), .err_exp(err_exp),
    .err_act(err_act), .pass_cnt(pass_cnt), .mismatch_cnt(mismatch_cnt),
    .rbw_cnt(rbw_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit pulse, fm, fr, fi;
    logic [AW-1:0] addr;
    logic [DW-1:0] exp, act;
    int pass, mm, rbw;
  } snap_t;

  typedef struct {
    int due;
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } pend_t;

  snap_t expq[$];
  pend_t pend[$];

  // Reference model: last write per table index, held as full address + data.
  logic [AW-1:0] tbl_addr [int];
  logic [DW-1:0] tbl_data [int];
  int m_pass, m_mm, m_rbw;
  bit m_fm, m_fr, m_fi;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_exp, m_act;

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    snap_t s;
    if (expq.size() > 0 && expq[0].cyc == cyc) begin
      s = expq.pop_front();
      check("err_pulse",    32'(err_pulse),    32'(s.pulse));
      check("err_mismatch", 32'(err_mismatch), 32'(s.fm));
      check("err_rbw",      32'(err_rbw),      32'(s.fr));
      check("err_illegal",  32'(err_illegal),  32'(s.fi));
      check("err_addr",     32'(err_addr),     32'(s.addr));
      check("err_exp",      32'(err_exp),      32'(s.exp));
      check("err_act",      32'(err_act),      32'(s.act));
      check("pass_cnt",     32'(pass_cnt),     32'(s.pass));
      check("mismatch_cnt", 32'(mismatch_cnt), 32'(s.mm));
      check("rbw_cnt",      32'(rbw_cnt),      32'(s.rbw));
    end
  end

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_clear();
    tbl_addr.delete();
    tbl_data.delete();
    pend.delete();
    m_pass = 0; m_mm = 0; m_rbw = 0;
    m_fm = 0; m_fr = 0; m_fi = 0;
    m_addr = '0; m_exp = '0; m_act = '0;
  endtask

  task automatic push_snap(input int c, input bit pulse);
    snap_t s;
    s.cyc = c; s.pulse = pulse; s.fm = m_fm; s.fr = m_fr; s.fi = m_fi;
    s.addr = m_addr; s.exp = m_exp; s.act = m_act;
    s.pass = m_pass; s.mm = m_mm; s.rbw = m_rbw;
    expq.push_back(s);
  endtask

  // One clock cycle of stimulus. rmode: 0 correct rdata, 1 forced rval,
  // 2 random corruption, applied only when a tracked read is due this cycle.
  task automatic drive(input logic rw, input logic c, input logic o,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic cl, input int rmode, input logic [DW-1:0] rval,
                       input bit chk);
    logic [DW-1:0] rd_v;
    bit due, bad, miss, ill, wr, rd;
    int idx;
    pend_t p;
    due = (pend.size() > 0 && pend[0].due == cyc);
    bad = 0; miss = 0;
    rd_v = DW'($urandom);
    if (due) begin
      p = pend.pop_front();
      case (rmode)
        0: rd_v = p.exp;
        1: rd_v = rval;
        default: rd_v = ($urandom_range(0, 4) == 0) ? p.exp ^ DW'(1 + $urandom_range(0, 254)) : p.exp;
      endcase
      bad = (rd_v != p.exp);
    end
    read_write = rw; cs = c; oe = o; address = a; wdata = wd; rdata = rd_v; clr = cl;
    wr = rw & c & ~o;
    rd = ~rw & c & o;
    ill = rw & c & o;
    idx = int'(a % (1 << IW));
    if (cl) begin
      model_clear();
    end else begin
      if (due) begin
        if (bad) begin
          m_mm = sat(m_mm); m_fm = 1;
          m_addr = p.addr; m_exp = p.exp; m_act = rd_v;
        end else begin
          m_pass = sat(m_pass);
        end
      end
      if (wr) begin
        tbl_addr[idx] = a;
        tbl_data[idx] = wd;
      end else if (rd) begin
        if (tbl_addr.exists(idx) && tbl_addr[idx] == a) begin
          p.due = cyc + RL; p.addr = a; p.exp = tbl_data[idx];
          pend.push_back(p);
        end else begin
          miss = 1;
          m_rbw = sat(m_rbw); m_fr = 1;
          if (!(due && bad)) m_addr = a;
        end
      end else if (ill) begin
        m_fi = 1;
        if (!(due && bad)) m_addr = a;
      end
    end
    if (chk) push_snap(cyc + 1, !cl && ((due && bad) || miss || ill));
    @(posedge clk);
    #1;
  endtask

  task automatic wr_op(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1, 1, 0, a, d, 0, 0, 0, 1);
  endtask

  task automatic rd_op(input logic [AW-1:0] a);
    drive(0, 1, 1, a, 0, 0, 0, 0, 1);
  endtask

  task automatic idle(input int n, input int rmode, input logic [DW-1:0] rval);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, rmode, rval, 1);
  endtask

  task automatic do_reset();
    expq.delete();
    rst_n = 0;
    read_write = 0; cs = 0; oe = 0; clr = 0; address = '0; wdata = '0;
    model_clear();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1;
    push_snap(cyc, 0);
  endtask

  initial begin
    int r;
    logic [AW-1:0] a;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // match at default latency path
    wr_op(30'h100, 8'hA5);
    rd_op(30'h100);
    idle(RL + 1, 0, 0);

    // mismatch with capture
    wr_op(30'h004, 8'h3C);
    rd_op(30'h004);
    idle(RL - 1, 0, 0);
    idle(1, 1, 8'h3D);
    idle(2, 0, 0);

    // read-before-write, then aliasing index with a different tag
    rd_op(30'h200);
    wr_op(30'h400, 8'h11);
    rd_op(30'h000);
    idle(2, 0, 0);

    // write after read in flight does not change expected data
    wr_op(30'h010, 8'h55);
    rd_op(30'h010);
    wr_op(30'h010, 8'h66);
    idle(RL, 0, 0);
    rd_op(30'h010);
    idle(RL + 1, 0, 0);

    // illegal command, table left untouched
    drive(1, 1, 1, 30'h7, 8'hEE, 0, 0, 0, 1);
    rd_op(30'h7);
    idle(2, 0, 0);

    // miss and mismatch completing in the same cycle
    wr_op(30'h020, 8'h77);
    rd_op(30'h020);
    idle(RL - 1, 0, 0);
    drive(0, 1, 1, 30'h3FF, 0, 0, 1, 8'h78, 1);
    idle(2, 0, 0);

    // reset with reads in flight: nothing stale may complete afterwards
    wr_op(30'h030, 8'h12);
    rd_op(30'h030);
    rd_op(30'h030);
    do_reset();
    idle(RL + 2, 0, 0);

    // randomized traffic over a small address pool
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      a = AW'(($urandom_range(0, 3) << IW) | $urandom_range(0, 7));
      if (r < 35)      drive(1, 1, 0, a, DW'($urandom), 0, 2, 0, 1);
      else if (r < 75) drive(0, 1, 1, a, DW'($urandom), 0, 2, 0, 1);
      else if (r < 85) drive(0, 0, 0, a, DW'($urandom), 0, 2, 0, 1);
      else if (r < 92) drive(1, 1, 1, a, DW'($urandom), 0, 2, 0, 1);
      else if (r < 95) drive(1'($urandom), 0, 1'($urandom), a, DW'($urandom), 0, 2, 0, 1);
      else if (r < 99) drive(0, 1, 0, a, DW'($urandom), 0, 2, 0, 1);
      else             drive(1'($urandom), 1, 1'($urandom), a, DW'($urandom), 1, 2, 0, 1);
    end
    idle(RL + 1, 0, 0);

    // counter saturation, then clr
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
    wr_op(30'h020, 8'h5A);
    for (int i = 0; i < (1 << CW) + 5; i++)
      drive(0, 1, 1, 30'h020, 0, 0, 0, 0, (i % 8192 == 0) || (i > (1 << CW) - 4));
    idle(RL + 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
    rd_op(30'h020);
    idle(3, 0, 0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
